// File: rtl/jt51_sh_ring_if.sv
// rtl/jt51_sh_ring_if.sv - control and read-out bundle for the jt51_sh_ring slot register
interface jt51_sh_ring_if #(
   parameter int WIDTH  = 5,
   parameter int STAGES = 32
);
   localparam int SW = (STAGES > 2) ? $clog2(STAGES) : 1;

   logic             en;
   logic             ld;
   logic [WIDTH-1:0] mask;
   logic [WIDTH-1:0] din;
   logic [WIDTH-1:0] drop;
   logic [WIDTH-1:0] tap;
   logic [SW-1:0]    slot;
   logic             zero;
   logic             valid;

   modport master (
      output en, ld, mask, din,
      input  drop, tap, slot, zero, valid
   );

   modport slave (
      input  en, ld, mask, din,
      output drop, tap, slot, zero, valid
   );
endinterface

// File: rtl/jt51_sh_ring.sv
// rtl/jt51_sh_ring.sv - circular time-slot register with bit-masked reload, slot counter,
// secondary tap and first-rotation-complete flag
module jt51_sh_ring #(
   parameter int               WIDTH  = 5,
   parameter int               STAGES = 32,
   parameter int               TAP    = 16,
   parameter logic [WIDTH-1:0] RSTVAL = '0
) (
   input  logic          clk,
   input  logic          rst_n,
   jt51_sh_ring_if.slave bus
);
   localparam int            SW   = (STAGES > 2) ? $clog2(STAGES) : 1;
   localparam logic [SW-1:0] LAST = SW'(STAGES - 1);

   logic [WIDTH-1:0] ring_q [STAGES];
   logic [WIDTH-1:0] ring_d [STAGES];
   logic [SW-1:0]    slot_q;
   logic [SW-1:0]    slot_d;
   logic             valid_q;
   logic             valid_d;
   logic [WIDTH-1:0] exit_w;
   logic [WIDTH-1:0] next_w;
   logic             wrap_w;

   // Position 0 is the slot being serviced; its word re-enters at the tail,
   // so the slot counter and the data stay locked together.
   always_comb begin
      exit_w  = ring_q[0];
      next_w  = bus.ld ? ((bus.din & bus.mask) | (exit_w & ~bus.mask)) : exit_w;
      wrap_w  = (slot_q == LAST);
      ring_d  = ring_q;
      slot_d  = slot_q;
      valid_d = valid_q;
      if (bus.en) begin
         for (int k = 0; k < STAGES - 1; k++) begin
            ring_d[k] = ring_q[k + 1];
         end
         ring_d[STAGES - 1] = next_w;
         slot_d             = wrap_w ? '0 : slot_q + SW'(1);
         valid_d            = valid_q | wrap_w;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < STAGES; k++) begin
            ring_q[k] <= RSTVAL;
         end
         slot_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            ring_q[k] <= ring_d[k];
         end
         slot_q  <= slot_d;
         valid_q <= valid_d;
      end
   end

   assign bus.drop  = ring_q[0];
   assign bus.tap   = ring_q[TAP];
   assign bus.slot  = slot_q;
   assign bus.zero  = (slot_q == '0);
   assign bus.valid = valid_q;
endmodule
